fetch_unit: RTL and testbench

- Instruction fetch stage of the core.
- Owns the fetch PC and issues single-outstanding word requests to instruction memory over a req/ack handshake.
- Delivers {instruction, pc} pairs to decode over a valid/ready handshake, with a one-entry hold (skid) register so that memory acks are never lost under backpressure.
- Accepts redirects (branch/jump targets) from the next-PC select path and flushes wrong-path work.

---
 rtl/lapido_pkg.sv | 16 +
 rtl/fetch_out_buffer.sv | 53 +++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lapido_pkg.sv
// Shared definitions for the fetch stage.
// Holds the FSM state encoding and the default widths and reset address.
package lapido_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_out_buffer.sv
// Decode-facing output registers plus a one-entry hold (skid) register.
// The hold register catches a memory word that arrives while decode is stalled.
module fetch_out_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  stash,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  drain,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    logic [DATA_WIDTH-1:0] hold_instr;
    logic [ADDR_WIDTH-1:0] hold_pc;

    // Flush wins over everything; a load and a pop are never requested together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_instr <= hold_instr;
            out_pc    <= hold_pc;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Hold contents are only meaningful while the FSM sits in HOLD.
    always_ff @(posedge clk) begin
        if (stash) begin
            hold_instr <= in_instr;
            hold_pc    <= in_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding memory
// requests and hands {instr, pc} pairs to decode, flushing on redirects.
module fetch_unit
    import lapido_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter int                    DATA_WIDTH = DATA_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF),
    parameter int                    PC_STEP    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    fetch_state_t          state, state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
    logic [ADDR_WIDTH-1:0] redir_buf, redir_buf_nxt;
    logic                  buf_load, buf_stash, buf_pop, buf_flush, buf_drain;
    logic                  slot_free;

    function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] pc);
        return pc + ADDR_WIDTH'(PC_STEP);
    endfunction

    assign imem_addr = fetch_pc;
    assign imem_req  = (state == FETCH) || (state == FLUSH);
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        redir_buf <= redir_buf_nxt;
    end

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        redir_buf_nxt = redir_buf;
        buf_load      = 1'b0;
        buf_stash     = 1'b0;
        buf_pop       = 1'b0;
        buf_flush     = 1'b0;
        buf_drain     = 1'b0;

        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect_valid) fetch_pc_nxt = redirect_pc;
            end
            FETCH: begin
                if (redirect_valid) begin
                    buf_flush = 1'b1;
                    // Without an ack the request must stay on the old address.
                    if (imem_ack) begin
                        fetch_pc_nxt = redirect_pc;
                    end else begin
                        redir_buf_nxt = redirect_pc;
                        state_nxt     = FLUSH;
                    end
                end else if (imem_ack) begin
                    fetch_pc_nxt = pc_inc(fetch_pc);
                    if (slot_free) begin
                        buf_load = 1'b1;
                    end else begin
                        buf_stash = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (out_ready) begin
                    buf_drain = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    buf_flush    = 1'b1;
                    fetch_pc_nxt = redirect_pc;
                    state_nxt    = FETCH;
                end else if (out_ready) begin
                    buf_pop   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FLUSH: begin
                if (redirect_valid) redir_buf_nxt = redirect_pc;
                if (imem_ack) begin
                    fetch_pc_nxt = redirect_valid ? redirect_pc : redir_buf;
                    state_nxt    = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    fetch_out_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buffer (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .stash    (buf_stash),
        .pop      (buf_pop),
        .flush    (buf_flush),
        .drain    (buf_drain),
        .in_instr (imem_rdata),
        .in_pc    (fetch_pc),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc   (out_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ SALT;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    // Transaction-level model: a running PC, an optional wrong-path request
    // still in flight, one visible output slot and a queue of stalled words.
    bit          m_started;
    logic [31:0] m_pc;
    bit          m_kill;
    logic [31:0] m_kill_tgt;
    bit          m_out_v;
    logic [31:0] m_out_i, m_out_pc;
    logic [63:0] m_wait[$];

    task automatic model_step();
        if (rst) begin
            m_started = 1'b0;
            m_pc      = '0;
            m_kill    = 1'b0;
            m_out_v   = 1'b0;
            m_out_i   = '0;
            m_out_pc  = '0;
            m_wait.delete();
        end else if (!m_started) begin
            m_started = 1'b1;
            if (redirect_valid) m_pc = redirect_pc;
        end else if (m_wait.size() != 0) begin
            if (redirect_valid) begin
                m_wait.delete();
                m_out_v = 1'b0;
                m_pc    = redirect_pc;
            end else if (out_ready) begin
                logic [63:0] w;
                w = m_wait.pop_front();
                m_out_v  = 1'b1;
                m_out_i  = w[63:32];
                m_out_pc = w[31:0];
            end
        end else if (m_kill) begin
            if (redirect_valid) m_kill_tgt = redirect_pc;
            if (imem_ack) begin
                m_pc   = m_kill_tgt;
                m_kill = 1'b0;
            end
        end else if (redirect_valid) begin
            m_out_v = 1'b0;
            if (imem_ack) m_pc = redirect_pc;
            else begin
                m_kill     = 1'b1;
                m_kill_tgt = redirect_pc;
            end
        end else if (imem_ack) begin
            if (!m_out_v || out_ready) begin
                m_out_v  = 1'b1;
                m_out_i  = m_pc ^ SALT;
                m_out_pc = m_pc;
            end else begin
                m_wait.push_back({m_pc ^ SALT, m_pc});
            end
            m_pc = m_pc + 32'd1;
        end else if (out_ready) begin
            m_out_v = 1'b0;
        end
    endtask

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_started && (m_wait.size() == 0)});
            chk("imem_addr", imem_addr, m_pc);
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_out_v});
            chk("out_instr", out_instr, m_out_i);
            chk("out_pc", out_pc, m_out_pc);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        chk_en = 1'b1;
        chk("rst_req_low", {31'd0, imem_req}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);

        // Reset release, zero-wait memory, decode always ready.
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk("req_before_edge", {31'd0, imem_req}, 32'd0);
        cyc();
        chk("req_rise", {31'd0, imem_req}, 32'd1);
        chk("first_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stream_pc", out_pc, 32'(i));
            chk("stream_instr", out_instr, 32'(i) ^ SALT);
        end

        // Backpressure for three cycles: pc 3 on output, pc 4 held.
        out_ready = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("hold_req_low", {31'd0, imem_req}, 32'd0);
        chk("hold_out_pc", out_pc, 32'd3);
        out_ready = 1'b1;
        cyc();
        chk("pop_pc4", out_pc, 32'd4);
        cyc();
        chk("next_pc5", out_pc, 32'd5);

        // Redirect while the request is still pending.
        imem_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        chk("flush_old_addr", imem_addr, 32'd6);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        cyc();
        imem_ack = 1'b1;
        cyc();
        chk("redir_addr", imem_addr, 32'h100);
        cyc();
        chk("redir_out_pc", out_pc, 32'h100);

        // Two redirects: the later target wins.
        imem_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cyc();
        redirect_pc = 32'h300;
        cyc();
        redirect_valid = 1'b0;
        imem_ack       = 1'b1;
        cyc();
        chk("latest_redir_addr", imem_addr, 32'h300);
        cyc();
        chk("latest_redir_pc", out_pc, 32'h300);

        // Redirect together with a decode handshake and a memory ack.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        cyc();
        chk("same_cycle_valid", {31'd0, out_valid}, 32'd0);
        chk("same_cycle_addr", imem_addr, 32'h400);

        // PC wrap at the top of the address space.
        redirect_pc = 32'hFFFF_FFFF;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("wrap_out_pc", out_pc, 32'hFFFF_FFFF);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset while a word sits in the hold register.
        out_ready = 1'b0;
        cyc();
        chk("hold2_req_low", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        cyc();
        chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        cyc();
        chk("rst_hold_restart", imem_addr, 32'h0);
        chk("rst_hold_req", {31'd0, imem_req}, 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            imem_ack       = ($urandom_range(0, 9) < 6);
            out_ready      = ($urandom_range(0, 9) < 7);
            cyc();
        end

        rst = 1'b1;
        cyc();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
